// File: rtl/injector_pkg.sv
// Shared flit layout and configuration constants for the local injection path.
package injector_pkg;

    localparam int IN_ROUTER_SIZE = 16;
    localparam int VALID          = 15;
    localparam int FLIT_NUM_MSB   = 14;
    localparam int FLIT_NUM_LSB   = 12;
    localparam int GOLDEN         = 11;

    typedef logic [IN_ROUTER_SIZE-1:0] flit_t;

    function automatic logic slot_free(input flit_t f);
        return (f[VALID] == 1'b0);
    endfunction

endpackage

// File: rtl/injector_fifo.sv
// inject_fifo: power-of-two synchronous FIFO with a separate occupancy counter.
module inject_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Next-state for storage, pointers and occupancy; pointers wrap naturally
    always_comb begin
        do_push_s = push && (count_q < DEPTH_C);
        do_pop_s  = pop && (count_q != {CW{1'b0}});
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards all contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/injector.sv
// injector: inserts buffered PE flits into empty channel slots after ejection.
// Optional starvation monitor enabled by defining INJECT_STARVE_EN.
module injector
    import injector_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [IN_ROUTER_SIZE-1:0]     pe_flit,
    input  logic                          pe_valid,
    output logic                          pe_ready,
    input  logic [IN_ROUTER_SIZE-1:0]     chan_flit_in,
    output logic [IN_ROUTER_SIZE-1:0]     chan_flit_out,
    output logic                          inject_fire,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          starve
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    flit_t          head_s;
    logic [CW-1:0]  count_s;
    logic           non_empty_s;

    inject_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (IN_ROUTER_SIZE)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pe_valid && pe_ready),
        .push_data (pe_flit),
        .pop       (inject_fire),
        .head      (head_s),
        .count     (count_s)
    );

    // Ready, inject condition and slot mux; occupied slots are never displaced
    always_comb begin
        non_empty_s = (count_s != {CW{1'b0}});
        pe_ready    = (count_s < DEPTH_C);
        inject_fire = non_empty_s && slot_free(chan_flit_in);
        if (inject_fire) begin
            chan_flit_out = head_s;
        end else begin
            chan_flit_out = chan_flit_in;
        end
    end

    assign fifo_count = count_s;

`ifdef INJECT_STARVE_EN
    localparam int SW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          starve_q, starve_d;

    // Blocked-cycle counter saturating at the limit; flag mirrors next count
    always_comb begin
        if (!non_empty_s || inject_fire) begin
            starve_cnt_d = {SW{1'b0}};
        end else if (starve_cnt_q == LIMIT_C) begin
            starve_cnt_d = starve_cnt_q;
        end else begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
        starve_d = (starve_cnt_d == LIMIT_C);
    end

    // Starvation state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= {SW{1'b0}};
            starve_q     <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            starve_q     <= starve_d;
        end
    end

    assign starve = starve_q;
`else
    assign starve = 1'b0;
`endif

endmodule

// File: doc/injector.md
# injector

Local-injection block for a router: the reverse path of the ejector. It buffers flits offered by the local processing element (PE) in a small FIFO. It inserts the head flit into the router's pipeline whenever the monitored channel slot arrives empty after ejection. Occupied slots pass through untouched, so injection never displaces in-flight traffic.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: injection buffer entries; power of two, ≥2.
- `STARVE_LIMIT`, default 16: cycles of blocked injection before `starve` asserts; only used with `INJECT_STARVE_EN`.

Ports:
- `clk` in 1: single clock for the block.
- `rst_n` in 1: asynchronous, active-low reset.
- `pe_flit` in `IN_ROUTER_SIZE`: flit offered by the local PE.
- `pe_valid` in 1: `pe_flit` is valid.
- `pe_ready` out 1: FIFO can accept a flit this cycle.
- `chan_flit_in` in `IN_ROUTER_SIZE`: channel slot after ejection. The slot is free when its `VALID` bit is 0.
- `chan_flit_out` out `IN_ROUTER_SIZE`: channel slot toward the permutation stage.
- `inject_fire` out 1: head flit is inserted this cycle.
- `fifo_count` out `$clog2(FIFO_DEPTH)+1`: current occupancy.
- `starve` out 1: injection starved. Present only with `INJECT_STARVE_EN`; otherwise tied 0.

## Operation
- Push: a flit is written on a rising `clk` when `pe_valid && pe_ready`.
- `pe_ready` = (`fifo_count` < `FIFO_DEPTH`). It is computed from registered occupancy and does not depend on a same-cycle pop.
- Inject condition: `inject_fire` = FIFO non-empty && `chan_flit_in[VALID]` == 0.
- Output mux:
  - When `inject_fire` is 1, `chan_flit_out` = FIFO head.
  - Otherwise `chan_flit_out` = `chan_flit_in`, bit-exact.
- Pop: the head is removed on the rising edge where `inject_fire` is 1.
- Simultaneous push and pop (not full): both happen and `fifo_count` is unchanged.
- Full: `pe_ready` stays 0 even if a pop happens in the same cycle. The pushed flit is taken one cycle later.
- Empty: no bypass. A flit pushed in cycle N is injectable no earlier than cycle N+1.
- Pointers: read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo `FIFO_DEPTH`. Occupancy is tracked by a separate counter, never by pointer comparison.
- Ordering: flits leave in push order. Flits of one packet are never reordered.
- The injected flit is forwarded unmodified. The PE is responsible for `VALID`=1, `FLIT_NUM` and the destination fields.

## Timing
- Channel path (`chan_flit_in` to `chan_flit_out`, `inject_fire`) is combinational, with zero added latency. It sits inside the router stage between ejection and permutation.
- Push-to-earliest-inject latency is 1 cycle.
- Values while `rst_n`=0, and reset values:
  - `fifo_count`=0, pointers=0 and starvation counter=0.
  - `pe_ready`=1 and `inject_fire`=0.
  - `chan_flit_out` = `chan_flit_in`, because the FIFO is empty.
  - `starve`=0.
- Reset mid-operation: FIFO contents are discarded and no partial flit is emitted. The PE must re-offer any flits lost this way.

## Configuration
- `INJECT_STARVE_EN` defined:
  - A saturating counter of `$clog2(STARVE_LIMIT)+1` bits increments each cycle with FIFO non-empty and `inject_fire`=0.
  - It clears to 0 on `inject_fire` or when the FIFO is empty.
  - `starve` is registered and equals (counter == `STARVE_LIMIT`).
  - `starve` deasserts on the edge after the next inject.
- Not defined: no counter exists and `starve` is constant 0.

## Structure
- Field positions (`VALID`, `FLIT_NUM`, `GOLDEN`, `IN_ROUTER_SIZE`) come from `globalVariable.v`. No new global constants are needed.
- One sub-module: `inject_fifo`, a parameterised synchronous FIFO with push, pop, head, count and async active-low reset.
- The top-level `injector` holds the inject condition, the output mux and the starvation counter.

## Test plan
- Idle pass-through: FIFO empty, `chan_flit_in` = {VALID=1, FLIT_NUM=5} → `chan_flit_out` identical, `inject_fire`=0, `pe_ready`=1.
- Single inject: push flit A in cycle 0; free slot in cycle 1 → `chan_flit_out`=A and `inject_fire`=1 in cycle 1; `fifo_count`=0 in cycle 2.
- Full and back-pressure (DEPTH=4):
  - Push 4 flits with all slots occupied → `fifo_count`=4, `pe_ready`=0.
  - Then free one slot → head injected, `pe_ready`=1 the next cycle.
  - Order A,B,C,D is preserved over 4 free slots.
- Simultaneous push/pop: count=2, push E while injecting → count stays 2; E emerges after the 2 older flits.
- Starvation (`INJECT_STARVE_EN`, LIMIT=16): one flit queued, slots busy 16 cycles → `starve`=1 on the 16th edge. Free a slot → inject, then `starve`=0 one edge later. Without the macro, `starve`=0 throughout.
- Async reset: assert `rst_n`=0 mid-cycle with count=3 → `fifo_count`=0, `inject_fire`=0 immediately; the channel passes through.
